s_cluster: RTL
==============

Name: s_cluster

Overview:
- Parametrised successor of the single-channel sequential logic module: CH independent logic channels.
- Each channel has a 2^SEL_W-entry truth table, gated select logic, an output flop with clock enable and a per-channel combinational-bypass bit.
- Truth tables and bypass bits are not ports. They are loaded through a serial configuration chain under an IDLE/LOAD/RUN state machine.
- Sits in the logic-cell fabric; CFG_DI/CFG_DO daisy-chain multiple clusters.

Parameters:
- CH, 4: number of logic channels.
- SEL_W, 2: select bits per channel; each truth table has 2^SEL_W entries.
- SEL_MODE, 'b10 (SEL_W bits): per select bit j, 0 = A&B gating, 1 = A|B gating. The default reproduces the legacy S0 = A0&B0, S1 = A1|B1.

Ports:
- CLK  in  1  system clock, rising edge.
- CLR_N  in  1  asynchronous, active-low reset.
- CE  in  1  output-flop clock enable.
- A  in  CH*SEL_W  select operand A; channel c uses A[c*SEL_W +: SEL_W].
- B  in  CH*SEL_W  select operand B, same layout as A.
- CFG_START  in  1  single-cycle pulse requesting a configuration load.
- CFG_VALID  in  1  CFG_DI holds a valid bit this cycle.
- CFG_DI  in  1  serial configuration data in.
- CFG_DO  out  1  serial configuration data out, for chaining.
- CFG_READY  out  1  high while in LOAD.
- CFG_DONE  out  1  high while in RUN.
- OUT  out  CH  channel outputs.

Behaviour:
- Chain sizing and layout:
  - CB = 2^SEL_W + 1 bits per channel; TOTAL = CH*CB.
  - Channel c occupies chain[c*CB +: CB]: bits [2^SEL_W-1:0] are truth table D, bit 2^SEL_W is BYP.
- Reset (CLR_N=0, asynchronous):
  - State = IDLE, chain = 0, bit counter = 0, output flops = 0.
  - OUT = 0, CFG_READY = 0, CFG_DONE = 0, CFG_DO = 0.
- State machine, one transition per rising CLK:
  - IDLE: OUT = 0. CFG_START=1 -> LOAD.
  - LOAD: CFG_READY = 1, OUT = 0, output flops cleared.
    - Each cycle with CFG_VALID=1: chain shifts right one bit; CFG_DI enters at bit TOTAL-1; the old bit 0 goes to registered CFG_DO; counter increments.
    - On the valid beat where counter == TOTAL-1: counter -> 0, state -> RUN.
    - The first bit sent ends in chain bit 0 (channel 0, D[0]).
    - CFG_START is ignored in LOAD. CFG_VALID=0 stalls with no change.
  - RUN: CFG_DONE = 1. CFG_VALID is ignored; the chain is frozen. CFG_START=1 -> LOAD, with output flops cleared on the same edge.
- Channel datapath, in RUN only:
  - Select bit j = SEL_MODE[j] ? (A_j | B_j) : (A_j & B_j).
  - sel = {bit SEL_W-1 .. bit 0}; m = D[sel].
  - Output flop: if CE=1 at the rising edge, flop <= m; otherwise it holds.
  - OUT[c] = BYP ? m (combinational, zero latency) : flop (one-cycle latency).
- Boundary cases:
  - CFG_START and CFG_VALID high in the same IDLE cycle: transition only; no bit is shifted.
  - The final LOAD beat with CE=1: the flop is not loaded. The first capture happens on the first RUN edge.
  - Reset mid-load: the partial configuration is discarded (chain = 0) and the state returns to IDLE.
  - CE is ignored outside RUN.

Decomposition:
- Shared package s_cluster_pkg:
  - state enum {IDLE, LOAD, RUN}.
  - Functions cb(SEL_W) and total(CH,SEL_W).
  - Counter width $clog2(TOTAL+1).
- One natural sub-module, s_cluster_ch: per-channel select gating, mux, flop and bypass, instantiated CH times by generate.
- The FSM and the configuration chain stay in the top module.

Test Plan:
- Reset behaviour: assert CLR_N=0 mid-cycle, then release -> OUT=0, CFG_READY=0, CFG_DONE=0 immediately and after release.
- Load with defaults (TOTAL=20): CFG_START pulse, then 20 valid beats for channel 0 D=4'b0110, BYP=0, all other channels 0 -> CFG_DONE rises on the edge of the 20th beat.
- Legacy select check: in RUN with A0=1, B0=1, A1=0, B1=0, so sel=1, and CE=1 -> OUT[0]=0 now and 1 after one edge. With CE=0 the output holds.
- Bypass: reload channel 1 with D=4'b1000, BYP=1. Set A1=1, B1=1, A0=1, B0=1 (sel=3) -> OUT[1]=1 in the same cycle, with no edge required.
- Stalls, reset mid-load and chaining:
  - CFG_VALID toggled every other cycle during load -> exactly 20 valid beats are needed.
  - CLR_N pulsed after 7 beats -> IDLE with chain=0.
  - CFG_DO replays the previously loaded bits in order.
- Reload from RUN: CFG_START pulse -> CFG_DONE=0, CFG_READY=1, OUT=0 on the next edge.

Source files
------------

// File: rtl/s_cluster_pkg.sv
// Shared types and sizing helpers for the s_cluster logic-channel cluster.
package s_cluster_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  // Chain bits per channel: the 2^sel_w truth-table entries plus one bypass bit.
  function automatic int cb(input int sel_w);
    return (1 << sel_w) + 1;
  endfunction

  function automatic int total(input int ch, input int sel_w);
    return ch * cb(sel_w);
  endfunction

  function automatic int cnt_w(input int ch, input int sel_w);
    return $clog2(total(ch, sel_w) + 1);
  endfunction

endpackage

// File: rtl/s_cluster_ch.sv
// One logic channel: gated select, truth-table mux, enabled output flop and bypass.
module s_cluster_ch
  import s_cluster_pkg::*;
#(
  parameter int               SEL_W    = 2,
  parameter logic [SEL_W-1:0] SEL_MODE = 'b10
) (
  input  logic                       clk,
  input  logic                       clr_n,
  input  logic                       ce,
  input  logic                       run,
  input  logic                       flop_clr,
  input  logic [SEL_W-1:0]           a,
  input  logic [SEL_W-1:0]           b,
  input  logic [cb(SEL_W)-2:0]       d,
  input  logic                       byp,
  output logic                       y
);

  logic [SEL_W-1:0] sel;
  logic             m;
  logic             flop_q;

  // Each select bit picks AND or OR gating of its operand pair.
  always_comb begin
    sel = '0;
    for (int j = 0; j < SEL_W; j++) begin
      sel[j] = SEL_MODE[j] ? (a[j] | b[j]) : (a[j] & b[j]);
    end
  end

  assign m = d[sel];

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      flop_q <= 1'b0;
    end else if (flop_clr) begin
      flop_q <= 1'b0;
    end else if (run && ce) begin
      flop_q <= m;
    end
  end

  assign y = run ? (byp ? m : flop_q) : 1'b0;

endmodule

// File: rtl/s_cluster.sv
// Cluster of CH logic channels whose truth tables and bypass bits arrive over a
// serial configuration chain that can be daisy-chained through CFG_DO.
//
//   state | meaning
//   IDLE  | unconfigured, outputs forced low, waiting for CFG_START
//   LOAD  | shifting configuration bits on CFG_VALID beats, outputs low
//   RUN   | configuration frozen, channels active
module s_cluster
  import s_cluster_pkg::*;
#(
  parameter int               CH       = 4,
  parameter int               SEL_W    = 2,
  parameter logic [SEL_W-1:0] SEL_MODE = 'b10
) (
  input  logic                CLK,
  input  logic                CLR_N,
  input  logic                CE,
  input  logic [CH*SEL_W-1:0] A,
  input  logic [CH*SEL_W-1:0] B,
  input  logic                CFG_START,
  input  logic                CFG_VALID,
  input  logic                CFG_DI,
  output logic                CFG_DO,
  output logic                CFG_READY,
  output logic                CFG_DONE,
  output logic [CH-1:0]       OUT
);

  localparam int CB    = cb(SEL_W);
  localparam int NE    = CB - 1;
  localparam int TOTAL = total(CH, SEL_W);
  localparam int CNT_W = cnt_w(CH, SEL_W);

  state_t            state_q;
  state_t            state_d;
  logic [TOTAL-1:0]  chain_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              cfg_do_q;
  logic              shift_en;
  logic              last_beat;
  logic              flop_clr;
  logic              run;

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_en  = 1'b0;
    last_beat = 1'b0;
    flop_clr  = 1'b0;
    CFG_READY = 1'b0;
    CFG_DONE  = 1'b0;
    case (state_q)
      IDLE: begin
        if (CFG_START) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        CFG_READY = 1'b1;
        flop_clr  = 1'b1;
        if (CFG_VALID) begin
          shift_en = 1'b1;
          if (cnt_q == CNT_W'(TOTAL - 1)) begin
            last_beat = 1'b1;
            state_d   = RUN;
          end
        end
      end
      RUN: begin
        CFG_DONE = 1'b1;
        if (CFG_START) begin
          state_d  = LOAD;
          flop_clr = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Shift right: the first bit sent lands in bit 0 after TOTAL beats.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      chain_q  <= '0;
      cnt_q    <= '0;
      cfg_do_q <= 1'b0;
    end else if (shift_en) begin
      chain_q  <= {CFG_DI, chain_q[TOTAL-1:1]};
      cfg_do_q <= chain_q[0];
      cnt_q    <= last_beat ? '0 : cnt_q + CNT_W'(1);
    end
  end

  assign CFG_DO = cfg_do_q;
  assign run    = (state_q == RUN);

  for (genvar c = 0; c < CH; c++) begin : g_ch
    s_cluster_ch #(
      .SEL_W    (SEL_W),
      .SEL_MODE (SEL_MODE)
    ) u_ch (
      .clk      (CLK),
      .clr_n    (CLR_N),
      .ce       (CE),
      .run      (run),
      .flop_clr (flop_clr),
      .a        (A[c*SEL_W +: SEL_W]),
      .b        (B[c*SEL_W +: SEL_W]),
      .d        (chain_q[c*CB +: NE]),
      .byp      (chain_q[c*CB + NE]),
      .y        (OUT[c])
    );
  end

endmodule
